// File: rtl/pueo_trig_timestamp.sv
// Trigger timestamper: stamps trigger strobes with {second, subsecond} relative to the last PPS
// and queues them, with an event number and status flags, in a first-word-fall-through FIFO.
module pueo_trig_timestamp #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [31:0] MAX_SUBSEC = 32'd130000000
) (
  input  logic                         sys_clk_i,
  input  logic                         sys_rst_n_i,
  input  logic                         en_i,
  input  logic                         trig_i,
  input  logic                         pps_flag_i,
  input  logic [31:0]                  cur_sec_i,
  input  logic [31:0]                  cur_time_i,
  input  logic [31:0]                  last_pps_i,
  output logic [63:0]                  m_tdata_o,
  output logic [17:0]                  m_tuser_o,
  output logic                         m_tvalid_o,
  input  logic                         m_tready_i,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count_o,
  output logic [15:0]                  drop_count_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(FIFO_DEPTH);

  // Entry layout: {long_second, no_pps, event[15:0], second[31:0], subsecond[31:0]}
  localparam int unsigned EntryW = 82;

  logic            cap_valid_q, cap_valid_d;
  logic [31:0]     cap_sec_q, cap_sec_d;
  logic [31:0]     cap_sub_q, cap_sub_d;
  logic            cap_no_pps_q, cap_no_pps_d;
  logic            cap_long_q, cap_long_d;
  logic            pps_seen_q, pps_seen_d;
  logic [15:0]     evt_q, evt_d;
  logic [15:0]     drop_q, drop_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic [EntryW-1:0] mem_q [FIFO_DEPTH];
  logic [EntryW-1:0] wr_entry;
  logic [EntryW-1:0] head;

  logic accept, valid, pop, room, push, drop;

  assign valid = (count_q != '0);
  assign pop   = valid && m_tready_i;
  assign room  = (count_q < DepthC) || pop;
  assign push  = cap_valid_q && room;
  assign drop  = cap_valid_q && !room;
  assign head  = mem_q[rd_ptr_q];

  // Stage 0: capture. A coincident PPS puts the trigger at the start of the next second while
  // the counter inputs still carry the previous second's values.
  always_comb begin
    accept       = trig_i && en_i;
    cap_valid_d  = accept;
    cap_sec_d    = cap_sec_q;
    cap_sub_d    = cap_sub_q;
    cap_no_pps_d = cap_no_pps_q;
    cap_long_d   = cap_long_q;
    if (accept) begin
      if (pps_flag_i) begin
        cap_sec_d = cur_sec_i + 32'd1;
        cap_sub_d = '0;
      end else begin
        cap_sec_d = cur_sec_i;
        cap_sub_d = cur_time_i - last_pps_i;
      end
      cap_no_pps_d = !pps_seen_q;
      cap_long_d   = (cap_sub_d > MAX_SUBSEC);
    end
    pps_seen_d = pps_seen_q || pps_flag_i;
  end

  // Stage 1: write. The event number is assigned here so dropped captures never consume one.
  always_comb begin
    wr_entry = {cap_long_q, cap_no_pps_q, evt_q, cap_sec_q, cap_sub_q};
    evt_d    = push ? evt_q + 16'd1 : evt_q;
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
    drop_d = drop_q;
    if (drop && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      cap_valid_q  <= 1'b0;
      cap_sec_q    <= '0;
      cap_sub_q    <= '0;
      cap_no_pps_q <= 1'b0;
      cap_long_q   <= 1'b0;
      pps_seen_q   <= 1'b0;
      evt_q        <= '0;
      drop_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      cap_valid_q  <= cap_valid_d;
      cap_sec_q    <= cap_sec_d;
      cap_sub_q    <= cap_sub_d;
      cap_no_pps_q <= cap_no_pps_d;
      cap_long_q   <= cap_long_d;
      pps_seen_q   <= pps_seen_d;
      evt_q        <= evt_d;
      drop_q       <= drop_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // Storage needs no reset: outputs are masked whenever the FIFO is empty.
  always_ff @(posedge sys_clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  assign m_tvalid_o   = valid;
  assign m_tdata_o    = valid ? head[63:0] : '0;
  assign m_tuser_o    = valid ? head[81:64] : '0;
  assign fifo_count_o = count_q;
  assign drop_count_o = drop_q;

endmodule

// File: doc/pueo_trig_timestamp.md
Name: pueo_trig_timestamp

Overview:
Downstream consumer of the PPS/time block, in the sysclk domain. Turns single-cycle trigger strobes into absolute timestamps: a second taken from the current-second counter, and a subsecond equal to the sysclk ticks since the last PPS flag. Timestamps, plus an event number and status flags, are buffered in a small FIFO. The FIFO drains over a valid/ready stream to the event builder.

Parameters:
FIFO_DEPTH, 16, timestamp FIFO entries; power of 2, range 4..256.
MAX_SUBSEC, 32'd130000000, subsecond above which the long_second flag is set (missed/absent PPS).

Ports:
sys_clk_i  input  1  system clock; sole clock.
sys_rst_n_i  input  1  asynchronous active-low reset.
en_i  input  1  trigger accept enable.
trig_i  input  1  trigger strobe; each high cycle is one trigger.
pps_flag_i  input  1  one-cycle PPS flag from the time block.
cur_sec_i  input  32  current second (updates the cycle after pps_flag_i).
cur_time_i  input  32  free-running sysclk tick counter.
last_pps_i  input  32  cur_time value captured at the last PPS (updates the cycle after pps_flag_i).
m_tdata_o  output  64  {second[63:32], subsecond[31:0]}.
m_tuser_o  output  18  [15:0] event number, [16] no_pps, [17] long_second.
m_tvalid_o  output  1  output entry valid.
m_tready_i  input  1  consumer ready.
fifo_count_o  output  log2(FIFO_DEPTH)+1  current occupancy.
drop_count_o  output  16  triggers dropped because the FIFO was full; saturating.

Behaviour:
- Async reset, active low.
  - All registers clear: m_tvalid_o=0, m_tdata_o=0, m_tuser_o=0, fifo_count_o=0, drop_count_o=0.
  - Event number = 0; pps_seen = 0; FIFO pointers = 0.
- Stage 0 (capture), on an edge with trig_i && en_i:
  - If pps_flag_i is also high this cycle: second = cur_sec_i+1, subsecond = 0. The trigger belongs to the new second; the counter inputs still hold old values this cycle.
  - Otherwise: second = cur_sec_i, subsecond = cur_time_i - last_pps_i, modulo 2^32. Wrap of cur_time is handled by this modular subtraction.
  - no_pps = !pps_seen, evaluated before this cycle's pps_flag_i. A coincident PPS therefore still reports no_pps=1 for the first PPS.
  - long_second = (subsecond > MAX_SUBSEC).
  - Event number is attached to the entry, then incremented, wrapping at 16 bits. It increments only for triggers written into the FIFO, not for dropped ones.
- pps_seen sets on the first pps_flag_i and stays set until reset.
- Stage 1 (write):
  - The registered capture is written to the FIFO on the next edge if there is room.
  - Room = count < FIFO_DEPTH, or a pop (m_tvalid_o && m_tready_i) occurs in the same cycle.
  - If there is no room, the entry is discarded and drop_count_o increments, saturating at 16'hFFFF.
- Latency:
  - Trigger sampled at edge N: m_tvalid_o goes high after edge N+1 when the FIFO was empty.
  - Back-to-back triggers every cycle are sustained at 1 entry/cycle.
- Output:
  - First-word-fall-through. m_tdata_o/m_tuser_o show the head entry whenever m_tvalid_o=1.
  - The head must stay stable until accepted; m_tvalid_o must not drop without a handshake.
  - Pop on m_tvalid_o && m_tready_i.
  - A simultaneous push and pop leaves the count unchanged.
- en_i low: triggers are ignored; no drop count, no event-number change. The FIFO keeps draining. A capture already in stage 1 still completes.
- Counters:
  - fifo_count_o reflects the post-edge occupancy and ranges 0..FIFO_DEPTH.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset mid-operation: the FIFO is flushed, an in-flight stage-1 capture is lost, and outputs return to reset values immediately (asynchronous).

Test Plan:
- Basic capture: after reset, pulse pps_flag_i with cur_sec_i=5. One cycle later set cur_sec_i=6, last_pps_i=1000; trig at cur_time_i=1250 -> entry {sec=6, sub=250}, event 0, no_pps=0, long_second=0; m_tvalid_o high 2 cycles after the trigger.
- Coincident PPS: trig_i and pps_flag_i in the same cycle with cur_sec_i=9 -> entry {sec=10, sub=0}. A trigger on the next cycle with updated inputs -> {sec=10, sub=1}.
- Wrap and no-PPS:
  - No PPS since reset, last_pps_i=32'hFFFFFFF0, cur_time_i=32'h10 -> sub=32'h20, no_pps=1.
  - sub=130000001 -> long_second=1.
- Full/drop: hold m_tready_i=0 and send FIFO_DEPTH+3 = 19 consecutive triggers -> fifo_count_o=16, drop_count_o=3. Drain 16 entries -> event numbers 0..15 in order. The next trigger carries event 16.
- Full with simultaneous pop: FIFO full, m_tready_i=1 and a trigger in the same cycle -> no drop, count stays 16, data ordering preserved.
- Enable and reset: en_i=0 with 4 triggers -> no entries, counters unchanged. Assert sys_rst_n_i with 5 entries queued -> m_tvalid_o=0, fifo_count_o=0 and drop_count_o=0 immediately, without waiting for a clock edge.
